adc_serial_reader: RTL and testbench
====================================

Name: adc_serial_reader

Overview:
- Upstream stage of the temperature calculator.
- Runs one conversion transaction per `start` pulse against a 3-wire serial temperature ADC (`cs_n`, `sclk`, `sdo`), shifting in 16 bits MSB-first.
- Presents the word as sign-magnitude `adc_data[15:0]`: bit 15 = sign, bits [14:0] = magnitude. The calculator consumes this combinationally.
- `adc_data` is held stable between conversions; `adc_valid` marks each update.

Parameters:
- CLK_DIV, 4, `clk` cycles per `sclk` half-period. Legal range 2..255; values below 2 are a configuration error.
- ADC_BITS, 16, bits per conversion word. Fixed by the downstream format; not to be overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one conversion. Sampled only in IDLE.
- sdo  in  1  serial data from ADC. Externally synchronised; treated as stable at the sampling edge.
- cs_n  out  1  ADC chip select, active low.
- sclk  out  1  serial clock. Idles low.
- busy  out  1  high from the cycle after `start` is accepted until the cycle `adc_valid` (or `parity_err`) pulses, inclusive.
- adc_data  out  16  last good conversion word, sign-magnitude. Held between updates.
- adc_valid  out  1  one-cycle pulse on each `adc_data` update.
- parity_err  out  1  one-cycle pulse on a rejected word. Constant 0 unless PARITY_EN is defined.

Behaviour:
- Reset values: `cs_n`=1, `sclk`=0, `busy`=0, `adc_data`=16'h0000, `adc_valid`=0, `parity_err`=0; state=IDLE; all counters 0.
- Reset mid-transaction aborts immediately. `cs_n` rises and `sclk` drops on the reset edge. No `adc_valid` is produced for the aborted word.
- States:
  - IDLE
  - SETUP: `cs_n` low, `sclk` low, for CLK_DIV cycles.
  - SHIFT: 16 bit periods. Each period is `sclk` low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - HOLD: `sclk` low, `cs_n` still low, for CLK_DIV cycles.
  - DONE: one cycle. `cs_n`=1, output update, then back to IDLE.
- IDLE→SETUP on the edge where `start`=1. `cs_n`=0 and `busy`=1 are visible from the next cycle.
- `start` outside IDLE is ignored (no queueing). `start` in the DONE cycle is also ignored.
- A new `start` is accepted at the earliest in the cycle after DONE.
- `sdo` is sampled on the `clk` edge at which `sclk` is driven 0→1, MSB first, into a shift register.
- Bit counter counts 0..15 and does not wrap; the SHIFT→HOLD transition happens after the 16th high phase.
- DONE: `adc_data` ← shift register, `adc_valid`=1 for exactly one cycle, `busy` falls the following cycle.
- Latency from the start-accepting edge to the `adc_valid` cycle is exactly 34*CLK_DIV+1 cycles (137 at default).
- No arithmetic interpretation in this block. Word 16'h8000 (negative zero) is passed through unchanged.
- `sclk` duty is exactly 50 %; no glitches. `sclk` and `cs_n` are registered outputs.

Optional Feature:
- Macro: ADC_SERIAL_READER_PARITY_EN.
- Defined:
  - SHIFT has 17 bit periods; bit 17 is an even-parity bit over all 17 bits.
  - On good parity: normal DONE.
  - On bad parity: `adc_data` keeps its previous value, `adc_valid` stays 0, `parity_err` pulses in the DONE cycle.
  - Latency 36*CLK_DIV+1.
- Undefined: 16 bits only, `parity_err` tied to 0, no parity logic synthesised.

Decomposition:
- Shared package `adc_pkg`:
  - state enum {IDLE, SETUP, SHIFT, HOLD, DONE}
  - ADC_BITS=16
  - ADC_SIGN_BIT=15
  - ADC_MAG_MSB=14
- One sub-module, `adc_sclk_gen`: half-period counter plus phase toggle, producing `sclk` and a `rise_strobe` / `period_done` strobe. Top-level FSM and shifter live in `adc_serial_reader`.

Test Plan:
- Reset, then idle 50 cycles → `cs_n`=1, `sclk`=0, `adc_data`=0000, no `adc_valid`.
- ADC model returns 16'h0320; pulse `start` → `cs_n` low next cycle; 16 `sclk` rises, each high phase 4 cycles; `adc_valid` exactly 137 cycles after accept; `adc_data`=0320; `busy` low next cycle.
- Return 16'h8150 then 16'h8000 in back-to-back transactions (`start` the cycle after DONE) → `adc_data` 8150 then 8000, two `adc_valid` pulses, no dropped start.
- Pulse `start` at cycles 10, 40 and at DONE of a transaction → only the first accepted; exactly one `adc_valid`.
- Assert `rst` at cycle 70 of a transaction returning 16'h7FFF → `cs_n`=1 and `sclk`=0 on the reset edge; `adc_data` stays 0000; no `adc_valid`.
- PARITY_EN defined: word 16'h0003 with parity 0 → `adc_valid`, `adc_data`=0003 at 145 cycles. Same word with parity 1 → `parity_err` pulse, `adc_data` unchanged, no `adc_valid`.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the serial temperature ADC reader.
// Optional parity mode is selected by ADC_SERIAL_READER_PARITY_EN.
package adc_pkg;

  localparam int unsigned ADC_BITS     = 16;
  localparam int unsigned ADC_SIGN_BIT = 15;
  localparam int unsigned ADC_MAG_MSB  = 14;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } adc_state_e;

  // True when the word plus its trailing parity bit carries an even number of ones.
  function automatic logic even_parity_ok(input logic [ADC_BITS:0] word);
    return ~^word;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: half-period counter plus phase toggle.
// While en_i is high the counter runs; while toggle_i is also high, sclk
// flips at each half-period boundary. Strobes are asserted in the cycle
// before the edge at which sclk changes.
module adc_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic toggle_i,
  output logic sclk_o,
  output logic half_done_o,
  output logic rise_strobe_o,
  output logic period_done_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic       sclk_q;

  assign half_done_o   = en_i && (cnt_q == DIV_LAST);
  assign rise_strobe_o = half_done_o && toggle_i && !sclk_q;
  assign period_done_o = half_done_o && toggle_i && sclk_q;
  assign sclk_o        = sclk_q;

  // Half-period counter and sclk phase; both collapse to zero when idle.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      if (cnt_q == DIV_LAST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (half_done_o && toggle_i) begin
        sclk_q <= ~sclk_q;
      end
    end
  end

endmodule

// File: rtl/adc_serial_reader.sv
// One conversion per start pulse against a 3-wire serial ADC.
// Shifts in the word MSB-first and presents it as sign-magnitude adc_data.
// Define ADC_SERIAL_READER_PARITY_EN to read a 17th even-parity bit and
// reject words that fail the check via parity_err.
module adc_serial_reader #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned ADC_BITS = adc_pkg::ADC_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sdo,
  output logic                cs_n,
  output logic                sclk,
  output logic                busy,
  output logic [ADC_BITS-1:0] adc_data,
  output logic                adc_valid,
  output logic                parity_err
);

  import adc_pkg::*;

`ifdef ADC_SERIAL_READER_PARITY_EN
  localparam int unsigned SHIFT_BITS = ADC_BITS + 1;
`else
  localparam int unsigned SHIFT_BITS = ADC_BITS;
`endif
  localparam logic [4:0] LAST_BIT = 5'(SHIFT_BITS - 1);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("adc_serial_reader: CLK_DIV must be in 2..255");
  end
  if (ADC_BITS != adc_pkg::ADC_BITS) begin : g_bad_adc_bits
    $error("adc_serial_reader: ADC_BITS is fixed by the downstream format");
  end

  adc_state_e            state_q;
  logic [4:0]            bit_cnt_q;
  logic [SHIFT_BITS-1:0] shift_q;
  logic                  cs_n_q;
  logic                  busy_q;
  logic [ADC_BITS-1:0]   data_q;
  logic                  valid_q;

  logic gen_en;
  logic gen_toggle;
  logic half_done;
  logic rise_strobe;
  logic period_done;

  assign gen_en     = state_q inside {SETUP, SHIFT, HOLD};
  assign gen_toggle = (state_q == SHIFT);

  adc_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (gen_en),
    .toggle_i     (gen_toggle),
    .sclk_o       (sclk),
    .half_done_o  (half_done),
    .rise_strobe_o(rise_strobe),
    .period_done_o(period_done)
  );

`ifdef ADC_SERIAL_READER_PARITY_EN
  logic perr_q;
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign cs_n      = cs_n_q;
  assign busy      = busy_q;
  assign adc_data  = data_q;
  assign adc_valid = valid_q;

  // Transaction FSM, serial shifter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
`ifdef ADC_SERIAL_READER_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef ADC_SERIAL_READER_PARITY_EN
      perr_q  <= 1'b0;
`endif
      // sdo is captured on the same edge that drives sclk high.
      if (rise_strobe) begin
        shift_q <= {shift_q[SHIFT_BITS-2:0], sdo};
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          if (half_done) begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (period_done) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= HOLD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end
        HOLD: begin
          if (half_done) begin
            state_q <= DONE;
            cs_n_q  <= 1'b1;
`ifdef ADC_SERIAL_READER_PARITY_EN
            if (even_parity_ok(shift_q)) begin
              data_q  <= shift_q[SHIFT_BITS-1 -: ADC_BITS];
              valid_q <= 1'b1;
            end else begin
              perr_q  <= 1'b1;
            end
`else
            data_q  <= shift_q[SHIFT_BITS-1 -: ADC_BITS];
            valid_q <= 1'b1;
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Self-checking bench for adc_serial_reader with a behavioural ADC model.
module tb_adc_serial_reader;

  localparam int D = 4;
`ifdef ADC_SERIAL_READER_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  // setup + NB full sclk periods + hold, then the DONE cycle
  localparam int LAT = D * (2 + 2 * NB) + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sdo;
  logic        cs_n;
  logic        sclk;
  logic        busy;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        parity_err;

  int          nchk;
  int          nfail;
  logic [15:0] model_data;
  logic [16:0] tx_word;
  int          bitptr = 0;

  always #5 clk = ~clk;

  adc_serial_reader #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sdo       (sdo),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .busy      (busy),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .parity_err(parity_err)
  );

  // ADC model: MSB presented when selected, next bit after each sclk fall.
  always @(negedge cs_n) bitptr = NB - 1;
  always @(negedge sclk) if (!cs_n && bitptr > 0) bitptr = bitptr - 1;
  always_comb sdo = tx_word[bitptr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction; called at a negedge, returns at a negedge with the DUT idle.
  task automatic run_txn(input logic [15:0] w, input bit bad_par, input bit inject, input int rst_at);
    int cyc, lat, nval, nperr, rises, hi, hibad, lows;
    bit prev, done, good;
`ifdef ADC_SERIAL_READER_PARITY_EN
    tx_word = {w, (^w) ^ bad_par};
    good = !bad_par;
`else
    tx_word = {1'b0, w};
    good = 1'b1;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("cs_n_low_after_accept", cs_n, 1'b0);
    chk("busy_after_accept", busy, 1'b1);
    lat = 0; nval = 0; nperr = 0; rises = 0; hi = 0; hibad = 0; prev = 1'b0; done = 1'b0;
    for (int k = 0; k < 700 && !done; k++) begin
      if (rst_at != 0 && cyc == rst_at) begin
        chk("cs_n_low_before_abort", cs_n, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_data = 16'h0000;
        chk("abort_cs_n", cs_n, 1'b1);
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_data", adc_data, model_data);
        nval = 0; lows = 0;
        for (int j = 0; j < 150; j++) begin
          @(negedge clk);
          if (adc_valid !== 1'b0) nval++;
          if (cs_n !== 1'b1) lows++;
        end
        chk("abort_no_valid", nval, 0);
        chk("abort_no_restart", lows, 0);
        chk("abort_data_hold", adc_data, model_data);
        return;
      end
      if (sclk && !prev) rises++;
      if (sclk) hi++;
      else begin
        if (prev && hi != D) hibad++;
        hi = 0;
      end
      prev = sclk;
      if (adc_valid) begin nval++; if (lat == 0) lat = cyc; end
      if (parity_err) begin nperr++; if (lat == 0) lat = cyc; end
      if (!busy) done = 1'b1;
      else begin
        start = inject && (cyc == 10 || cyc == 40 || adc_valid || parity_err);
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    chk("txn_completes", done, 1'b1);
    chk("latency", lat, LAT);
    chk("busy_fall_cycle", cyc, LAT + 1);
    chk("sclk_rises", rises, NB);
    chk("sclk_high_phase", hibad, 0);
    if (good) begin
      model_data = w;
      chk("valid_pulses", nval, 1);
      chk("perr_pulses", nperr, 0);
    end else begin
      chk("valid_pulses_bad", nval, 0);
      chk("perr_pulses_bad", nperr, 1);
    end
    chk("adc_data", adc_data, model_data);
    if (inject) begin
      lows = 0;
      for (int j = 0; j < 60; j++) begin
        @(negedge clk);
        if (cs_n !== 1'b1 || busy !== 1'b0) lows++;
      end
      chk("ignored_starts", lows, 0);
    end
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; tx_word = '0; nchk = 0; nfail = 0; model_data = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || sclk !== 1'b0 || adc_valid !== 1'b0 || busy !== 1'b0 || parity_err !== 1'b0)
        bad++;
    end
    chk("idle_outputs", bad, 0);
    chk("reset_data", adc_data, 16'h0000);

    run_txn(16'h0320, 1'b0, 1'b0, 0);
    repeat (5) @(negedge clk);
    run_txn(16'h8150, 1'b0, 1'b0, 0);
    run_txn(16'h8000, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    run_txn(16'($urandom), 1'b0, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_txn(16'($urandom), 1'b0, 1'b0, 0);
    end
    run_txn(16'h7FFF, 1'b0, 1'b0, 70);
    run_txn(16'($urandom), 1'b0, 1'b0, 75);
    run_txn(16'h1234, 1'b0, 1'b0, 0);
`ifdef ADC_SERIAL_READER_PARITY_EN
    run_txn(16'h0003, 1'b0, 1'b0, 0);
    run_txn(16'h0003, 1'b1, 1'b0, 0);
    run_txn(16'($urandom), 1'b1, 1'b0, 0);
    run_txn(16'($urandom), 1'b0, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
